encoder8_3_stream: RTL
======================

ENCODER8_3_STREAM -- requirements
Module: encoder8_3_stream

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk edge.
REQ-004 en  input  1  block enable; 0 = stall, with no capture and no emission.
REQ-005 in_valid  input  1  req vector presented.
REQ-006 in_ready  output  1  block can accept a vector; high iff state IDLE.
REQ-007 req  input  8  multi-hot request vector; bit i requests code i.
REQ-008 out_valid  output  1  code is valid.
REQ-009 out_ready  input  1  downstream accepts code.
REQ-010 code  output  3  binary index of the lowest set bit still pending.
REQ-011 last  output  1  current code is the final one for the captured vector.
REQ-012 count  output  4  popcount (0..8) of the most recently captured vector; held until the next capture.
REQ-013 zero_err  output  1  one-cycle pulse when an all-zero vector is captured.

Function
REQ-014 The block SHALL have two states: IDLE and EMIT, with an internal 8-bit register pending.
REQ-015 Capture SHALL occur on a rising edge where state=IDLE, en=1 and in_valid=1; in_ready is combinationally equal to (state==IDLE).
REQ-016 On capture with req!=0, the block SHALL load pending<=req, count<=popcount(req) and state<=EMIT.
REQ-017 On capture with req==0, the block SHALL stay in IDLE, leave pending at 0, load count<=0 and assert zero_err for exactly the next cycle.
REQ-018 zero_err SHALL be 0 in every other cycle.
REQ-019 out_valid SHALL equal (state==EMIT && en==1), so the first code is visible one cycle after capture.
REQ-020 code SHALL be the index of the lowest-numbered 1 in pending (bit 0 = highest priority); code SHALL be 0 when pending==0.
REQ-021 last SHALL be 1 iff pending has exactly one bit set, qualified by out_valid.
REQ-022 code and last SHALL depend only on registered state, never combinationally on req, in_valid or out_ready.
REQ-023 On a rising edge with out_valid=1 and out_ready=1, the block SHALL clear the bit of pending selected by code.
REQ-024 If last=1 at that transfer, state SHALL return to IDLE, so in_ready is high in the next cycle.
REQ-025 While out_valid=1 and out_ready=0, code, last and pending SHALL hold unchanged.
REQ-026 en=0 in EMIT SHALL force out_valid to 0, hold state and pending, and resume the emission when en returns to 1.
REQ-027 en=0 in IDLE SHALL block capture; in_ready remains high.
REQ-028 A new vector SHALL NOT be accepted while in EMIT; in_valid in EMIT is ignored.
REQ-029 Throughput SHALL be one code per cycle under continuous out_ready=1 and en=1.
REQ-030 An N-bit vector SHALL occupy N+1 cycles from capture edge to in_ready high again.
REQ-031 Codes for one vector SHALL be emitted in strictly ascending index order with no duplicates and no omissions.

Reset
REQ-032 When rst=1 at a rising edge, the block SHALL set state=IDLE, pending=0, count=0 and zero_err=0.
REQ-033 After reset, outputs SHALL read in_ready=1, out_valid=0, code=0 and last=0.
REQ-034 Reset SHALL take priority over capture, transfer and en in the same cycle.
REQ-035 Reset during EMIT SHALL abandon the remaining pending codes with no further out_valid.

Verification
REQ-036 Single bit: rst, then req=8'b0010_0000 captured -> one beat code=5, last=1, count=1; in_ready high 2 cycles after capture.
REQ-037 Full vector: req=8'hFF with out_ready=1 -> codes 0,1,...,7 on consecutive cycles, last only on code 7, count=8, in_ready back after 9 cycles.
REQ-038 Backpressure: req=8'b1000_0101 with out_ready low for 3 cycles at first beat -> code=0 held stable 3 cycles, then codes 0,2,7 emitted, last on 7.
REQ-039 Zero vector: req=8'h00 captured -> zero_err pulse 1 cycle, count=0, out_valid never asserts, state stays IDLE.
REQ-040 Enable stall: req=8'h0C, en=0 after code 2 is accepted -> out_valid=0 while en=0; code=3 with last=1 once en=1.
REQ-041 Reset mid-stream: req=8'hF0, rst pulse after code 4 is accepted -> next cycle out_valid=0, in_ready=1, count=0; new req=8'h01 yields code=0, last=1.

Source files
------------

// File: rtl/encoder8_3_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | encoder8_3_stream_if : request-vector in / priority-code out bus   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface encoder8_3_stream_if;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] req;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] code;
  logic       last;
  logic [3:0] count;
  logic       zero_err;

  modport slave (
    input  en, in_valid, req, out_ready,
    output in_ready, out_valid, code, last, count, zero_err
  );

  modport master (
    output en, in_valid, req, out_ready,
    input  in_ready, out_valid, code, last, count, zero_err
  );
endinterface
`default_nettype wire

// File: rtl/encoder8_3_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | encoder8_3_stream : streams the set-bit indices of a captured      |
// | 8-bit request vector, lowest index first. rev 1.0                  |
// +--------------------------------------------------------------------+
module encoder8_3_stream (
  input  logic                clk,
  input  logic                rst,
  encoder8_3_stream_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] pending, pending_nxt;
  logic [3:0] count_r, count_nxt;
  logic       zero_err_r, zero_err_nxt;

  logic [2:0] low_idx;
  logic       single;
  logic [3:0] req_pop;
  logic       out_valid;
  logic       capture;
  logic       transfer;

  // Scan downward so the lowest set bit is the one left standing.
  always_comb begin
    low_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) low_idx = 3'(i);
    end
  end

  assign single = (pending != 8'd0) && ((pending & (pending - 8'd1)) == 8'd0);

  always_comb begin
    req_pop = '0;
    for (int i = 0; i < 8; i++) begin
      req_pop = req_pop + {3'b000, bus.req[i]};
    end
  end

  assign out_valid = (state == EMIT) && bus.en;
  assign capture   = (state == IDLE) && bus.en && bus.in_valid;
  assign transfer  = out_valid && bus.out_ready;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.code      = low_idx;
  assign bus.last      = single && out_valid;
  assign bus.count     = count_r;
  assign bus.zero_err  = zero_err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= '0;
      count_r    <= '0;
      zero_err_r <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      count_r    <= count_nxt;
      zero_err_r <= zero_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    count_nxt    = count_r;
    zero_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          if (bus.req != 8'd0) begin
            pending_nxt = bus.req;
            count_nxt   = req_pop;
            state_nxt   = EMIT;
          end else begin
            count_nxt    = 4'd0;
            zero_err_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        if (transfer) begin
          pending_nxt = pending & ~(8'd1 << low_idx);
          if (single) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire
